// File: rtl/arbitro_contador_pkg.sv
// Shared constants and FSM encoding for the round-robin ones-counter front end.
package arbitro_contador_pkg;

   localparam int unsigned DEF_N_REQ  = 4;
   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_RES_W  = 5;
   localparam int unsigned DEF_TMO    = 63;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RESP      = 3'd4
   } state_e;

endpackage

// File: rtl/arbitro_contador_if.sv
// Requester and engine signals of arbitro_contador; slave is the arbiter side.
interface arbitro_contador_if
   import arbitro_contador_pkg::*;
#(
   parameter int unsigned N_REQ  = DEF_N_REQ,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RES_W  = DEF_RES_W
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] dados;
   logic [N_REQ-1:0]        ack;
   logic [N_REQ-1:0]        done;
   logic [RES_W-1:0]        resultado;
   logic                    erro;
   logic                    ocupado;
   logic [DATA_W-1:0]       eng_A;
   logic                    eng_start;
   logic                    eng_pronto;
   logic [RES_W-1:0]        eng_resultado;

   modport master (
      output req, dados, eng_pronto, eng_resultado,
      input  ack, done, resultado, erro, ocupado, eng_A, eng_start
   );

   modport slave (
      input  req, dados, eng_pronto, eng_resultado,
      output ack, done, resultado, erro, ocupado, eng_A, eng_start
   );
endinterface

// File: rtl/arbitro_contador_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);
   logic [IDX_W-1:0] pos;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      pos     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         pos = IDX_W'((32'(ptr_i) + k) % N_REQ);
         if (!any_o && req_i[pos]) begin
            any_o        = 1'b1;
            grant_o[pos] = 1'b1;
            idx_o        = pos;
         end
      end
   end
endmodule

// File: rtl/arbitro_contador.sv
// Round-robin arbiter sharing one external ones-counter engine among N_REQ requesters,
// with a completion timeout that answers resultado=0 and erro=1.
module arbitro_contador
   import arbitro_contador_pkg::*;
#(
   parameter int unsigned N_REQ  = DEF_N_REQ,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RES_W  = DEF_RES_W,
   parameter int unsigned TMO    = DEF_TMO
) (
   input  logic               clk,
   input  logic               reset,
   arbitro_contador_if.slave  bus
);
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TMO_W = $clog2(TMO + 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d, owner_q, owner_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic [RES_W-1:0]  res_q, res_d;
   logic [N_REQ-1:0]  ack_q, ack_d, done_q, done_d;
   logic              erro_q, erro_d, start_q, start_d, ocup_q, ocup_d;

   logic [N_REQ-1:0]  grant;
   logic [IDX_W-1:0]  gidx;
   logic              gany;
   logic [DATA_W-1:0] op_sel;
   logic              tmo_hit;

   rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (gidx),
      .any_o   (gany)
   );

   // Operand of the current round-robin winner.
   always_comb begin
      op_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gidx == IDX_W'(i)) op_sel = bus.dados[i*DATA_W +: DATA_W];
      end
   end

   // tmo_q counts cycles since ISSUE; hitting TMO-1 puts done exactly TMO cycles after ISSUE.
   assign tmo_hit = (tmo_q == TMO_W'(TMO - 1));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      tmo_d   = tmo_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      ack_d   = '0;
      done_d  = '0;
      erro_d  = 1'b0;
      start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (gany) begin
               state_d = S_ISSUE;
               ack_d   = grant;
               owner_d = gidx;
               opnd_d  = op_sel;
               ptr_d   = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
               tmo_d   = '0;
               start_d = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
            tmo_d   = tmo_q + TMO_W'(1);
         end
         S_WAIT_BUSY: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_hit) begin
               state_d = S_RESP;
               res_d   = '0;
               erro_d  = 1'b1;
               done_d  = N_REQ'(1) << owner_q;
            end else if (!bus.eng_pronto) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (bus.eng_pronto) begin
               state_d = S_RESP;
               res_d   = bus.eng_resultado;
               done_d  = N_REQ'(1) << owner_q;
            end else if (tmo_hit) begin
               state_d = S_RESP;
               res_d   = '0;
               erro_d  = 1'b1;
               done_d  = N_REQ'(1) << owner_q;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ocup_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         tmo_q   <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         erro_q  <= 1'b0;
         start_q <= 1'b0;
         ocup_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         tmo_q   <= tmo_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         erro_q  <= erro_d;
         start_q <= start_d;
         ocup_q  <= ocup_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.done      = done_q;
   assign bus.resultado = res_q;
   assign bus.erro      = erro_q;
   assign bus.ocupado   = ocup_q;
   assign bus.eng_A     = opnd_q;
   assign bus.eng_start = start_q;
endmodule

// File: tb/tb_arbitro_contador.sv
// Scoreboard bench for arbitro_contador with a behavioural ones-counter engine.
module tb_arbitro_contador;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned RES_W  = 5;
   localparam int unsigned TMO    = 63;
   localparam int unsigned BUSY   = 3;

   typedef struct {
      logic [N_REQ-1:0] owner;
      logic [RES_W-1:0] res;
      logic             erro;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   arbitro_contador_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

   arbitro_contador #(.N_REQ(N_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .TMO(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_chk = 0, n_fail = 0, cyc = 0, start_cnt = 0, issue_cyc = 0;
   exp_t sbq[$];
   logic stuck = 1'b0, hold = 1'b0;

   logic [N_REQ-1:0]        req_s   = '0;
   logic [N_REQ*DATA_W-1:0] dados_s = '0;
   logic                    rst_s   = 1'b1;
   logic                    m_idle = 1'b1, done_prev = 1'b0;
   int                      m_ptr  = 0;
   logic [N_REQ-1:0]        hold_seq [5];

   logic             eng_pronto_m = 1'b1;
   logic [RES_W-1:0] eng_res_m    = '0;
   int               eng_cnt      = 0;
   assign bus.eng_pronto    = eng_pronto_m;
   assign bus.eng_resultado = eng_res_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [RES_W-1:0] popcnt(input logic [DATA_W-1:0] v);
      logic [RES_W-1:0] r;
      r = '0;
      for (int b = 0; b < DATA_W; b++) r = r + RES_W'(v[b]);
      return r;
   endfunction

   // Engine: drops pronto for BUSY cycles after a start, never returns while stuck.
   always @(posedge clk) begin
      if (bus.eng_start) begin
         eng_pronto_m <= 1'b0;
         eng_cnt      <= BUSY;
         eng_res_m    <= RES_W'($countones(bus.eng_A));
      end else if (!stuck && eng_cnt != 0) begin
         if (eng_cnt == 1) eng_pronto_m <= 1'b1;
         eng_cnt <= eng_cnt - 1;
      end
   end

   always @(posedge clk) begin
      req_s   <= bus.req;
      dados_s <= bus.dados;
      rst_s   <= reset;
      cyc     <= cyc + 1;
   end

   // Reference arbiter: predicts ack/eng_start/ocupado every cycle, queues the expected done.
   always @(negedge clk) begin
      logic [N_REQ-1:0]  exp_ack;
      logic [DATA_W-1:0] opnd;
      logic              idle_c;
      exp_t              e;
      int                w, win;
      if (reset) begin
         chk("rst_ack", bus.ack, 0);
         chk("rst_done", bus.done, 0);
         chk("rst_erro", bus.erro, 0);
         chk("rst_start", bus.eng_start, 0);
         chk("rst_ocupado", bus.ocupado, 0);
         chk("rst_resultado", bus.resultado, 0);
         chk("rst_eng_A", bus.eng_A, 0);
         sbq.delete();
         m_idle    = 1'b1;
         done_prev = 1'b0;
         m_ptr     = 0;
      end else begin
         exp_ack = '0;
         win     = 0;
         if (m_idle && !rst_s) begin
            for (int k = 0; k < N_REQ; k++) begin
               w = (m_ptr + k) % N_REQ;
               if (exp_ack == 0 && req_s[w]) begin
                  exp_ack[w] = 1'b1;
                  win        = w;
               end
            end
         end
         chk("ack", bus.ack, exp_ack);
         chk("eng_start", bus.eng_start, 32'(exp_ack != 0));
         if (exp_ack != 0) begin
            opnd    = dados_s[win*DATA_W +: DATA_W];
            m_ptr   = (win + 1) % N_REQ;
            chk("eng_A", bus.eng_A, opnd);
            e.owner = exp_ack;
            e.res   = stuck ? RES_W'(0) : popcnt(opnd);
            e.erro  = stuck;
            sbq.push_back(e);
            issue_cyc = cyc;
            start_cnt++;
         end
         if (bus.done != 0) begin
            if (sbq.size() == 0) begin
               chk("done_spur", bus.done, 0);
            end else begin
               e = sbq.pop_front();
               chk("done", bus.done, e.owner);
               chk("resultado", bus.resultado, e.res);
               chk("erro", bus.erro, e.erro);
               if (e.erro) chk("tmo_lat", cyc - issue_cyc, TMO);
            end
         end else begin
            chk("erro_idle", bus.erro, 0);
         end
         idle_c = (m_idle && exp_ack == 0) || done_prev;
         chk("ocupado", bus.ocupado, 32'(!idle_c));
         m_idle    = idle_c;
         done_prev = (bus.done != 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      if (!hold) bus.req = bus.req & ~bus.ack;
   endtask

   task automatic set_op(input int i, input logic [DATA_W-1:0] v);
      bus.dados[i*DATA_W +: DATA_W] = v;
   endtask

   task automatic wait_quiet(input int max);
      int   n;
      logic quiet;
      n     = 0;
      quiet = 1'b0;
      while (!quiet && n < max) begin
         tick();
         n++;
         quiet = (bus.req == 0) && (sbq.size() == 0) && m_idle;
      end
      chk("quiet", 32'(quiet), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int               n, k, s;
      logic [N_REQ-1:0] m;
      bus.req   = '0;
      bus.dados = '0;
      hold_seq[0] = 4'b0001; hold_seq[1] = 4'b0010; hold_seq[2] = 4'b0100;
      hold_seq[3] = 4'b1000; hold_seq[4] = 4'b0001;
      repeat (3) tick();
      reset = 1'b0;

      // Two simultaneous requesters from ptr=0: 0 then 2.
      set_op(0, 16'h0001); set_op(2, 16'h00F0);
      bus.req = 4'b0101;
      wait_quiet(200);

      set_op(0, 16'hFFFF); bus.req = 4'b0001; wait_quiet(200);
      set_op(0, 16'h0000); bus.req = 4'b0001; wait_quiet(200);
      set_op(3, 16'hAAAA); bus.req = 4'b1000; wait_quiet(200);

      // All requesters held high: strict rotation.
      do_reset();
      for (int i = 0; i < N_REQ; i++) set_op(i, DATA_W'(16'h0101 << i));
      hold    = 1'b1;
      bus.req = '1;
      n = 0; k = 0;
      while (n < 5 && k < 200) begin
         tick();
         k++;
         if (bus.ack != 0) begin
            chk("hold_seq", bus.ack, hold_seq[n]);
            n++;
         end
      end
      chk("hold_cnt", n, 5);
      hold    = 1'b0;
      bus.req = '0;
      wait_quiet(300);

      // Engine never finishes; a late request is dropped before it can be served.
      stuck = 1'b1;
      set_op(1, 16'hFFFF);
      bus.req = 4'b0010;
      repeat (4) tick();
      set_op(2, 16'h0F0F);
      bus.req[2] = 1'b1;
      repeat (5) tick();
      bus.req[2] = 1'b0;
      wait_quiet(200);
      stuck = 1'b0;
      repeat (5) tick();

      // Random traffic, including requests raised mid-transaction.
      for (int it = 0; it < 8; it++) begin
         m = N_REQ'($urandom_range(1, 15));
         for (int i = 0; i < N_REQ; i++) if (m[i]) set_op(i, DATA_W'($urandom));
         bus.req = m;
         repeat (3) tick();
         m = N_REQ'($urandom_range(0, 15)) & ~bus.req;
         for (int i = 0; i < N_REQ; i++) if (m[i]) set_op(i, DATA_W'($urandom));
         bus.req = bus.req | m;
         wait_quiet(400);
      end

      // Reset while waiting on the engine: everything clears, no done for it.
      stuck = 1'b1;
      set_op(1, 16'h1234);
      bus.req = 4'b0010;
      s = start_cnt;
      k = 0;
      while (start_cnt == s && k < 50) begin
         tick();
         k++;
      end
      chk("rst_setup", start_cnt - s, 1);
      repeat (4) tick();
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("now_ack", bus.ack, 0);
      chk("now_done", bus.done, 0);
      chk("now_erro", bus.erro, 0);
      chk("now_start", bus.eng_start, 0);
      chk("now_ocupado", bus.ocupado, 0);
      chk("now_resultado", bus.resultado, 0);
      chk("now_eng_A", bus.eng_A, 0);
      stuck = 1'b0;
      for (int i = 0; i < N_REQ; i++) set_op(i, DATA_W'(16'h8001 >> i));
      bus.req = '1;
      repeat (3) tick();
      reset = 1'b0;
      k = 0;
      while (bus.ack == 0 && k < 20) begin
         tick();
         k++;
      end
      chk("first_grant", bus.ack, 4'b0001);
      wait_quiet(400);
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/arbitro_contador.md
ARBITRO_CONTADOR -- requirements
Module: arbitro_contador

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one ones-counter engine.
REQ-002 Parameter DATA_W, default 16, operand width.
REQ-003 Parameter RES_W, default 5, result width (holds 0..DATA_W).
REQ-004 Parameter TMO, default 63, maximum cycles waited for engine completion.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  N_REQ  per-requester level request; held until the matching ack bit.
REQ-008 dados  in  N_REQ*DATA_W  operands; slice i is valid while req[i]=1.
REQ-009 ack  out  N_REQ  one-hot, one-cycle pulse; winning operand latched.
REQ-010 done  out  N_REQ  one-hot, one-cycle pulse; resultado valid for that requester.
REQ-011 resultado  out  RES_W  count of ones; valid only when done is nonzero.
REQ-012 erro  out  1  one-cycle pulse coincident with done on engine timeout.
REQ-013 ocupado  out  1  high in every state except IDLE.
REQ-014 eng_A  out  DATA_W  operand to the engine; held constant from ISSUE through WAIT_DONE.
REQ-015 eng_start  out  1  engine start, one-cycle pulse.
REQ-016 eng_pronto  in  1  engine ready/finished level.
REQ-017 eng_resultado  in  RES_W  engine result; sampled when eng_pronto=1 in WAIT_DONE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-019 IDLE: if any req bit set, pick winner round-robin, pulse ack[winner], latch operand and owner index, go to ISSUE next cycle.
REQ-020 Round-robin: search starts at pointer ptr, wraps N_REQ-1 -> 0; after a grant, ptr = winner+1 modulo N_REQ.
REQ-021 ISSUE: eng_start=1 for exactly this cycle; go to WAIT_BUSY.
REQ-022 WAIT_BUSY: stay while eng_pronto=1; go to WAIT_DONE when eng_pronto=0.
REQ-023 WAIT_DONE: on eng_pronto=1 capture eng_resultado, go to RESP.
REQ-024 Timeout counter clears on ISSUE and increments each cycle in WAIT_BUSY/WAIT_DONE; reaching TMO forces RESP with resultado=0 and erro=1.
REQ-025 RESP: done[owner]=1 for one cycle with resultado; go to IDLE; ack for the next winner no earlier than the following cycle.
REQ-026 Minimum grant-to-done latency: 4 cycles plus engine busy time; one transaction in flight at most.
REQ-027 req bits raised during a transaction are not acked until IDLE; a req dropped before ack is never served.
REQ-028 Requester keeping req high after its ack is treated as a new request at the next IDLE.
REQ-029 eng_start, ack, done, erro are never high in IDLE without the conditions above.

Reset
REQ-030 reset=1 immediately forces IDLE, ptr=0, timeout=0, latched operand/owner/result=0.
REQ-031 During and after reset: ack=0, done=0, erro=0, eng_start=0, ocupado=0, resultado=0, eng_A=0.
REQ-032 Reset mid-transaction discards it; no done is ever issued for it.

Structure
REQ-033 Shared package holds the FSM state encoding and default parameter constants.
REQ-034 One combinational sub-module rr_picker (req, ptr -> one-hot grant, index, any) is used.
REQ-035 Engine is external; this block only drives/samples the eng_* ports.

Verification
REQ-036 Single req[0], dados slice0=16'hFFFF, engine model 3-cycle busy -> ack[0], eng_start once, done[0] with resultado=16, erro=0.
REQ-037 req[0] and req[2] together, operands 16'h0001 and 16'h00F0 -> order 0 then 2, results 1 then 4.
REQ-038 All four req held high continuously -> acks in order 0,1,2,3,0; no bit served twice before others.
REQ-039 Operand 16'h0000 -> done with resultado=0; operand 16'hAAAA -> resultado=8.
REQ-040 Engine holds eng_pronto=0 forever -> done[owner] and erro pulse TMO cycles after ISSUE, resultado=0, block returns to IDLE.
REQ-041 reset asserted in WAIT_DONE -> all outputs 0 same cycle, no done; post-reset first grant goes to req[0].
